// File: rtl/bcd_display_scan.sv
// bcd_display_scan: latches a packed BCD word and time-multiplexes it onto a common-anode 7-segment display
module bcd_display_scan #(
  parameter int DIGITS         = 5,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] bcdin,
  input  logic                load,
  input  logic                blank_lz,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                err
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [4*DIGITS-1:0] hold;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          nib;
  logic                hi_zero, blank, bad_in, last;
  logic [6:0]          glyph, seg_nxt;
  logic [DIGITS-1:0]   an_nxt;
  assign last = cnt == CW'(REFRESH_DIV - 1);
  assign dp   = SEG_ACTIVE_LOW;
  // select the scanned nibble, decide blanking, decode to active-high segments
  always_comb begin
    nib     = hold[4*idx +: 4];
    hi_zero = 1'b1;
    bad_in  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      hi_zero = hi_zero & ((i < int'(idx)) | (hold[4*i +: 4] == 4'd0));
      bad_in  = bad_in | (bcdin[4*i +: 4] > 4'd9);
    end
    blank = blank_lz & (idx != '0) & hi_zero;
    case (nib)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
    seg_nxt = blank ? 7'h00 : glyph;
    an_nxt  = blank ? '0 : DIGITS'(1) << idx;
  end
  // hold register, refresh scan and registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      cnt  <= '0;
      idx  <= '0;
      err  <= 1'b0;
      an   <= {DIGITS{AN_ACTIVE_LOW}};
      seg  <= {7{SEG_ACTIVE_LOW}};
    end else begin
      if (load) begin
        hold <= bcdin;
        err  <= bad_in;
      end
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      an  <= an_nxt ^ {DIGITS{AN_ACTIVE_LOW}};
      seg <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized and directed checks of the display scanner against a value-level model
module tb_bcd_display_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] bcdin = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [4:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err;
  int          total = 0;
  int          bad = 0;
  int          m_hold = 0;
  int          m_cnt = 0;
  int          m_idx = 0;
  int          m_err = 0;
  int          e_an = 'h1F;
  int          e_seg = 'h7F;
  int          seg_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F,
                                'h40, 'h40, 'h40, 'h40, 'h40, 'h40};
  bcd_display_scan #(.DIGITS(5), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bcdin(bcdin), .load(load), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int nibble(input int v, input int i);
    return (v >> (4 * i)) & 'hF;
  endfunction
  // one clock: advance the model across the edge, then compare on the falling edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_hold = 0; m_cnt = 0; m_idx = 0; m_err = 0;
      e_an = 'h1F; e_seg = 'h7F;
    end else begin
      if (blank_lz && m_idx > 0 && (m_hold >> (4 * m_idx)) == 0) begin
        e_an = 'h1F; e_seg = 'h7F;
      end else begin
        e_an  = ~(1 << m_idx) & 'h1F;
        e_seg = ~seg_tab[nibble(m_hold, m_idx)] & 'h7F;
      end
      if (load) begin
        m_hold = int'(bcdin);
        m_err = 0;
        for (int i = 0; i < 5; i++) if (nibble(m_hold, i) > 9) m_err = 1;
      end
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 5;
      end
    end
    @(negedge clk);
    check("an", int'(an), e_an);
    check("seg", int'(seg), e_seg);
    check("dp", int'(dp), 1);
    check("err", int'(err), m_err);
  endtask
  task automatic load_word(input logic [19:0] v);
    bcdin = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    logic [19:0] v;
    int          guard;
    run(3);
    rst_n = 1'b1;
    tick();
    check("first_slot_an", int'(an), 'h1E);
    load_word(20'h65535);
    run(24);
    blank_lz = 1'b1;
    load_word(20'h00042);
    run(22);
    load_word(20'h00000);
    run(22);
    blank_lz = 1'b0;
    load_word(20'h0A012);
    run(22);
    check("err_sticky", int'(err), 1);
    load_word(20'h00001);
    check("err_clear", int'(err), 0);
    guard = 0;
    while (m_cnt != 3 && guard < 10) begin
      tick();
      guard++;
    end
    check("align_guard", int'(guard < 10), 1);
    load_word(20'h12345);
    run(6);
    guard = 0;
    while (m_idx != 3 && guard < 30) begin
      tick();
      guard++;
    end
    check("idx3_guard", int'(guard < 30), 1);
    rst_n = 1'b0;
    tick();
    check("midscan_reset_an", int'(an), 'h1F);
    rst_n = 1'b1;
    run(10);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        v = '0;
        for (int i = 0; i < 5; i++)
          v[4*i +: 4] = $urandom_range(0, 11) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        v = v >> (4 * $urandom_range(0, 4));
        bcdin = v;
        load = 1'b1;
      end else begin
        bcdin = 20'($urandom);
        load = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst_n = $urandom_range(0, 199) != 0;
      tick();
    end
    load = 1'b0;
    rst_n = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
